// File: rtl/ramp_gen_if.sv
// Control/status bundle for ramp_gen: step request, mode/step select in; ramp value and status out.
interface ramp_gen_if #(
   parameter int unsigned WIDTH = 12
);
   logic             ramp_enb;
   logic             delta;
   logic [1:0]       Y;
   logic [1:0]       mode;
   logic [WIDTH-1:0] out;
   logic             dir;
   logic             wrap;
   logic             at_max;

   modport master (
      output ramp_enb, delta, Y, mode,
      input  out, dir, wrap, at_max
   );

   modport slave (
      input  ramp_enb, delta, Y, mode,
      output out, dir, wrap, at_max
   );
endinterface

// File: rtl/ramp_gen.sv
// Multi-mode ramp generator (sawtooth / saturate / triangle / hold) with wrap and limit status.
// Define RAMP_STEP_EDGE_EN to step once per rising edge of delta instead of every cycle it is high.
module ramp_gen #(
   parameter int unsigned WIDTH = 12,
   parameter int unsigned STEP0 = 0,
   parameter int unsigned STEP1 = 1,
   parameter int unsigned STEP2 = 16,
   parameter int unsigned STEP3 = 1290,
   parameter int unsigned MAX   = 2**WIDTH - 1
) (
   input logic       clk,
   input logic       rst,
   ramp_gen_if.slave bus
);

   typedef enum logic [1:0] {IDLE, UP, DOWN} state_e;
   typedef enum logic [1:0] {M_SAW = 2'b00, M_SAT = 2'b01, M_TRI = 2'b10, M_HOLD = 2'b11} mode_e;

   localparam logic [WIDTH:0] MAX_W  = (WIDTH+1)'(MAX);
   localparam logic [WIDTH:0] WRAP_W = (WIDTH+1)'(MAX) + (WIDTH+1)'(1);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] out_q, out_d;
   logic             dir_q, dir_d;
   logic             wrap_q, wrap_d;
   logic             strobe;
   mode_e            mode;
   logic [WIDTH:0]   step;
   logic [WIDTH:0]   cur;
   logic [WIDTH:0]   sum;

`ifdef RAMP_STEP_EDGE_EN
   logic delta_q;
   assign strobe = bus.delta & ~delta_q;
`else
   assign strobe = bus.delta;
`endif

   assign mode = mode_e'(bus.mode);

   always_comb begin
      case (bus.Y)
         2'b00:   step = (WIDTH+1)'(STEP0);
         2'b01:   step = (WIDTH+1)'(STEP1);
         2'b10:   step = (WIDTH+1)'(STEP2);
         default: step = (WIDTH+1)'(STEP3);
      endcase
   end

   always_comb begin
      state_d = state_q;
      out_d   = out_q;
      dir_d   = dir_q;
      wrap_d  = 1'b0;
      cur     = {1'b0, out_q};
      sum     = cur + step;

      if (!bus.ramp_enb) begin
         state_d = IDLE;
         out_d   = '0;
         dir_d   = 1'b1;
      end else if (mode == M_HOLD) begin
         if (state_q == IDLE) state_d = UP;
      end else if (state_q == DOWN && mode != M_TRI) begin
         // Dropping out of a descending triangle only restores direction; the value is kept.
         state_d = UP;
         dir_d   = 1'b1;
      end else begin
         if (state_q == IDLE) state_d = UP;
         if (strobe && step != '0) begin
            case (mode)
               M_SAW: begin
                  if (sum > MAX_W) begin
                     out_d  = WIDTH'(sum - WRAP_W);
                     wrap_d = 1'b1;
                  end else begin
                     out_d = WIDTH'(sum);
                  end
               end
               M_SAT: out_d = (sum > MAX_W) ? WIDTH'(MAX_W) : WIDTH'(sum);
               M_TRI: begin
                  if (state_q == DOWN) begin
                     if (cur <= step) begin
                        out_d   = '0;
                        dir_d   = 1'b1;
                        wrap_d  = 1'b1;
                        state_d = UP;
                     end else begin
                        out_d = WIDTH'(cur - step);
                     end
                  end else if (sum >= MAX_W) begin
                     out_d   = WIDTH'(MAX_W);
                     dir_d   = 1'b0;
                     state_d = DOWN;
                  end else begin
                     out_d = WIDTH'(sum);
                  end
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         out_q   <= '0;
         dir_q   <= 1'b1;
         wrap_q  <= 1'b0;
`ifdef RAMP_STEP_EDGE_EN
         delta_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         out_q   <= out_d;
         dir_q   <= dir_d;
         wrap_q  <= wrap_d;
`ifdef RAMP_STEP_EDGE_EN
         delta_q <= bus.delta;
`endif
      end
   end

   assign bus.out    = out_q;
   assign bus.dir    = dir_q;
   assign bus.wrap   = wrap_q;
   assign bus.at_max = ({1'b0, out_q} == MAX_W);

endmodule

// File: tb/tb_ramp_gen.sv
// Self-checking bench for ramp_gen: directed scenarios plus randomized traffic against a value-level model.
module tb_ramp_gen;
   localparam int unsigned WIDTH = 12;
   localparam int MAXV = 4095;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   int   m_out;
   bit   m_up;
   bit   m_wrap;
   bit   m_prev;
   int   steps [4] = '{0, 1, 16, 1290};

   ramp_gen_if #(.WIDTH(WIDTH)) bus ();

   ramp_gen #(
      .WIDTH(WIDTH), .STEP0(0), .STEP1(1), .STEP2(16), .STEP3(1290), .MAX(MAXV)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   // Advance one clock edge, updating the reference from the inputs present at that edge.
   task automatic tick();
      bit strobe;
      int st;
      int s;
`ifdef RAMP_STEP_EDGE_EN
      strobe = bus.delta && !m_prev;
`else
      strobe = bus.delta;
`endif
      st = steps[bus.Y];
      s  = m_out + st;
      m_wrap = 1'b0;
      if (rst) begin
         m_out = 0; m_up = 1'b1; m_prev = 1'b0;
      end else begin
         m_prev = bus.delta;
         if (!bus.ramp_enb) begin
            m_out = 0; m_up = 1'b1;
         end else if (bus.mode == 2'd3) begin
         end else if (!m_up && bus.mode != 2'd2) begin
            m_up = 1'b1;
         end else if (strobe && st != 0) begin
            if (bus.mode == 2'd0) begin
               if (s > MAXV) begin m_out = s - (MAXV + 1); m_wrap = 1'b1; end
               else m_out = s;
            end else if (bus.mode == 2'd1) begin
               m_out = (s > MAXV) ? MAXV : s;
            end else if (m_up) begin
               if (s >= MAXV) begin m_out = MAXV; m_up = 1'b0; end
               else m_out = s;
            end else begin
               if (m_out <= st) begin m_out = 0; m_up = 1'b1; m_wrap = 1'b1; end
               else m_out = m_out - st;
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic pulse();
      bus.delta = 1'b1; tick();
      bus.delta = 1'b0; tick();
   endtask

   task automatic clear_and_enable();
      bus.ramp_enb = 1'b0; bus.delta = 1'b0; tick();
      bus.ramp_enb = 1'b1; tick();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.ramp_enb = 1'b0; bus.delta = 1'b0; bus.Y = 2'd0; bus.mode = 2'd0;
      tick(); tick();
      checks++;
      if (bus.out !== 12'd0 || bus.dir !== 1'b1 || bus.wrap !== 1'b0 || bus.at_max !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: out=%0d dir=%b wrap=%b at_max=%b, expected 0/1/0/0",
                  bus.out, bus.dir, bus.wrap, bus.at_max);
      end
      rst = 1'b0;
   endtask

   task automatic test_sawtooth();
      int exp_out [4] = '{1290, 2580, 3870, 1064};
      clear_and_enable();
      bus.mode = 2'd0; bus.Y = 2'd3;
      for (int i = 0; i < 4; i++) begin
         bus.delta = 1'b1; tick();
         checks++;
         if (bus.out !== 12'(exp_out[i]) || bus.wrap !== (i == 3)) begin
            errors++;
            $display("FAIL sawtooth_%0d: out=%0d wrap=%b, expected %0d wrap=%b",
                     i, bus.out, bus.wrap, exp_out[i], (i == 3));
         end
         bus.delta = 1'b0; tick();
         checks++;
         if (bus.wrap !== 1'b0) begin
            errors++;
            $display("FAIL sawtooth_wrap_clear_%0d: wrap=%b, expected 0", i, bus.wrap);
         end
      end
   endtask

   task automatic test_saturate();
      clear_and_enable();
      bus.mode = 2'd0;
      bus.Y = 2'd3; repeat (3) pulse();
      bus.Y = 2'd2; repeat (13) pulse();
      bus.Y = 2'd1; repeat (10) pulse();
      checks++;
      if (bus.out !== 12'd4088) begin
         errors++;
         $display("FAIL saturate_setup: out=%0d, expected 4088", bus.out);
      end
      bus.mode = 2'd1; bus.Y = 2'd2;
      for (int i = 0; i < 2; i++) begin
         bus.delta = 1'b1; tick();
         checks++;
         if (bus.out !== 12'd4095 || bus.at_max !== 1'b1 || bus.wrap !== 1'b0) begin
            errors++;
            $display("FAIL saturate_%0d: out=%0d at_max=%b wrap=%b, expected 4095/1/0",
                     i, bus.out, bus.at_max, bus.wrap);
         end
         bus.delta = 1'b0; tick();
      end
   endtask

   task automatic test_triangle();
      int exp_out [8] = '{1290, 2580, 3870, 4095, 2805, 1515, 225, 0};
      bit exp_dir [8] = '{1, 1, 1, 0, 0, 0, 0, 1};
      clear_and_enable();
      bus.mode = 2'd2; bus.Y = 2'd3;
      for (int i = 0; i < 8; i++) begin
         bus.delta = 1'b1; tick();
         checks++;
         if (bus.out !== 12'(exp_out[i]) || bus.dir !== exp_dir[i] || bus.wrap !== (i == 7)) begin
            errors++;
            $display("FAIL triangle_%0d: out=%0d dir=%b wrap=%b, expected %0d dir=%b wrap=%b",
                     i, bus.out, bus.dir, bus.wrap, exp_out[i], exp_dir[i], (i == 7));
         end
         bus.delta = 1'b0; tick();
      end
   endtask

   task automatic test_step_zero_and_leave();
      clear_and_enable();
      bus.mode = 2'd2; bus.Y = 2'd3;
      repeat (4) pulse();
      bus.Y = 2'd0;
      bus.delta = 1'b1; tick();
      checks++;
      if (bus.out !== 12'd4095 || bus.dir !== 1'b0 || bus.wrap !== 1'b0) begin
         errors++;
         $display("FAIL step_zero_at_max: out=%0d dir=%b wrap=%b, expected 4095/0/0",
                  bus.out, bus.dir, bus.wrap);
      end
      bus.delta = 1'b0; bus.mode = 2'd0; bus.Y = 2'd3; tick();
      checks++;
      if (bus.out !== 12'd4095 || bus.dir !== 1'b1) begin
         errors++;
         $display("FAIL leave_triangle: out=%0d dir=%b, expected 4095/1", bus.out, bus.dir);
      end
   endtask

   task automatic test_hold();
      clear_and_enable();
      bus.mode = 2'd0; bus.Y = 2'd2;
      pulse();
      bus.mode = 2'd3; bus.Y = 2'd3;
      repeat (2) pulse();
      checks++;
      if (bus.out !== 12'd16 || bus.dir !== 1'b1 || bus.wrap !== 1'b0) begin
         errors++;
         $display("FAIL hold: out=%0d dir=%b wrap=%b, expected 16/1/0", bus.out, bus.dir, bus.wrap);
      end
   endtask

   task automatic test_disable();
      clear_and_enable();
      bus.mode = 2'd0; bus.Y = 2'd3;
      repeat (2) pulse();
      checks++;
      if (bus.out !== 12'd2580) begin
         errors++;
         $display("FAIL disable_setup: out=%0d, expected 2580", bus.out);
      end
      bus.ramp_enb = 1'b0;
      for (int i = 0; i < 4; i++) begin
         bus.delta = (i % 2 == 0);
         tick();
         checks++;
         if (bus.out !== 12'd0 || bus.dir !== 1'b1 || bus.wrap !== 1'b0) begin
            errors++;
            $display("FAIL disable_%0d: out=%0d dir=%b wrap=%b, expected 0/1/0",
                     i, bus.out, bus.dir, bus.wrap);
         end
      end
      bus.ramp_enb = 1'b1; bus.delta = 1'b0;
   endtask

   task automatic test_level_vs_edge();
      logic [11:0] exp_final;
`ifdef RAMP_STEP_EDGE_EN
      exp_final = 12'd1;
`else
      exp_final = 12'd5;
`endif
      clear_and_enable();
      bus.mode = 2'd0; bus.Y = 2'd1;
      bus.delta = 1'b1;
      repeat (5) tick();
      checks++;
      if (bus.out !== exp_final) begin
         errors++;
         $display("FAIL delta_held: out=%0d, expected %0d", bus.out, exp_final);
      end
      bus.delta = 1'b0; tick();
   endtask

   task automatic test_reset_mid_run();
      clear_and_enable();
      bus.mode = 2'd0; bus.Y = 2'd3;
      pulse();
      #2;
      rst = 1'b1;
      #1;
      m_out = 0; m_up = 1'b1; m_wrap = 1'b0; m_prev = 1'b0;
      checks++;
      if (bus.out !== 12'd0 || bus.dir !== 1'b1 || bus.wrap !== 1'b0) begin
         errors++;
         $display("FAIL reset_async: out=%0d dir=%b wrap=%b, expected 0/1/0", bus.out, bus.dir, bus.wrap);
      end
      bus.delta = 1'b1;
      for (int i = 0; i < 3; i++) begin
         bus.delta = ~bus.delta;
         tick();
         checks++;
         if (bus.out !== 12'd0) begin
            errors++;
            $display("FAIL reset_held_%0d: out=%0d, expected 0", i, bus.out);
         end
      end
      rst = 1'b0;
      bus.delta = 1'b0;
      tick();
   endtask

   task automatic test_random();
      for (int i = 0; i < 600; i++) begin
         bus.ramp_enb = ($urandom_range(0, 19) != 0);
         bus.delta    = 1'($urandom_range(0, 1));
         bus.Y        = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 9) == 0) bus.mode = 2'($urandom_range(0, 3));
         tick();
         checks++;
         if (bus.out !== 12'(m_out) || bus.dir !== m_up || bus.wrap !== m_wrap ||
             bus.at_max !== (m_out == MAXV)) begin
            errors++;
            $display("FAIL random_%0d: out=%0d dir=%b wrap=%b at_max=%b, expected %0d/%b/%b/%b",
                     i, bus.out, bus.dir, bus.wrap, bus.at_max, m_out, m_up, m_wrap, (m_out == MAXV));
         end
      end
   endtask

   initial begin
      m_out = 0; m_up = 1'b1; m_wrap = 1'b0; m_prev = 1'b0;
      test_reset();
      test_sawtooth();
      test_saturate();
      test_triangle();
      test_step_zero_and_leave();
      test_hold();
      test_disable();
      test_level_vs_edge();
      test_reset_mid_run();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
